// File: rtl/norm_scaler.sv
// Per-frame pixel normaliser: sequential reciprocal divide, then a 2-stage
// multiply/round/saturate AXI-Stream pipeline. Define NORM_SCALER_ROUND_EN for half-up rounding.
module norm_scaler #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int FRAC_BITS       = 8,
    parameter int OUT_ROWS        = 10,
    parameter int OUT_COLS        = 10
) (
    input  logic                       clk,
    input  logic                       s_axis_resetn,
    input  logic                       ap_start,
    output logic                       ap_ready,
    output logic                       ap_done,
    input  logic                       cf_ap_done,
    input  logic [PIXEL_BIT_WIDTH-1:0] norm_denominator,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tlast
);

    localparam int W   = PIXEL_BIT_WIDTH;
    localparam int F   = FRAC_BITS;
    localparam int C   = W + F;
    localparam int N   = OUT_ROWS * OUT_COLS;
    localparam int P   = 2 * W + F;
    localparam int PW  = P + 1;
    localparam int CW  = $clog2(N + 1);
    localparam int DCW = $clog2(C);

    localparam logic [C-1:0]   DIVIDEND = {{W{1'b1}}, {F{1'b0}}};
    localparam logic [W-1:0]   MAXV     = '1;
    localparam logic [CW-1:0]  N_CNT    = CW'(N);
    localparam logic [CW-1:0]  N_LAST   = CW'(N - 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(C - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV,
        S_WAIT_CF,
        S_STREAM,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]   den_q;
    logic [C-1:0]   dvd;
    logic [W-1:0]   rem;
    logic [C-1:0]   coef;
    logic [DCW-1:0] div_cnt;
    logic [W:0]     trial;
    logic           trial_ge;

    logic           cf_flag;
    logic [CW-1:0]  in_cnt;
    logic [CW-1:0]  out_cnt;

    logic           v1, v2;
    logic [P-1:0]   p1;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [P:0]     p_adj;
    logic [P:0]     p_shift;
    logic [W-1:0]   sat;

    logic start_acc, en, in_hs, out_hs;

    assign start_acc = (state == S_IDLE) && ap_start;
    assign en        = !v2 || m_axis_tready;
    assign in_hs     = s_axis_tvalid && s_axis_tready;
    assign out_hs    = v2 && m_axis_tready;
    assign trial     = {rem, dvd[C-1]};
    assign trial_ge  = trial >= {1'b0, den_q};

    always_comb begin
        state_nxt     = state;
        ap_ready      = 1'b0;
        ap_done       = 1'b0;
        s_axis_tready = 1'b0;
        unique case (state)
            S_IDLE: begin
                ap_ready = 1'b1;
                if (ap_start) state_nxt = S_DIV;
            end
            S_DIV: begin
                if (div_cnt == DIV_LAST) state_nxt = S_WAIT_CF;
            end
            S_WAIT_CF: begin
                if (cf_flag) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                s_axis_tready = (in_cnt < N_CNT) && en;
                if (out_hs && out_last) state_nxt = S_DONE;
            end
            S_DONE: begin
                ap_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) state <= S_IDLE;
        else                state <= state_nxt;
    end

    // Restoring divider; a zero denominator keeps the all-ones preset but still burns C cycles.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            den_q   <= '0;
            dvd     <= '0;
            rem     <= '0;
            coef    <= '0;
            div_cnt <= '0;
        end else if (start_acc) begin
            den_q   <= norm_denominator;
            dvd     <= DIVIDEND;
            rem     <= '0;
            coef    <= (norm_denominator == '0) ? '1 : '0;
            div_cnt <= '0;
        end else if (state == S_DIV) begin
            div_cnt <= div_cnt + DCW'(1);
            if (den_q != '0) begin
                dvd <= dvd << 1;
                if (trial_ge) begin
                    rem  <= trial[W-1:0] - den_q;
                    coef <= {coef[C-2:0], 1'b1};
                end else begin
                    rem  <= trial[W-1:0];
                    coef <= {coef[C-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            cf_flag <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (start_acc) begin
            cf_flag <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (state != S_IDLE && cf_ap_done) cf_flag <= 1'b1;
            if (in_hs) in_cnt <= in_cnt + CW'(1);
            if (v1 && en) out_cnt <= out_cnt + CW'(1);
        end
    end

`ifdef NORM_SCALER_ROUND_EN
    localparam logic [P:0] RND = PW'(1) << (F - 1);
    assign p_adj = {1'b0, p1} + RND;
`else
    assign p_adj = {1'b0, p1};
`endif
    assign p_shift = p_adj >> F;
    assign sat     = (p_shift > PW'(MAXV)) ? MAXV : p_shift[W-1:0];

    // Both stages advance on the same enable so backpressure freezes the whole pipe.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            v1       <= 1'b0;
            p1       <= '0;
            v2       <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (en) begin
            v1 <= in_hs;
            if (in_hs) p1 <= P'(s_axis_tdata) * P'(coef);
            v2 <= v1;
            if (v1) begin
                out_data <= sat;
                out_last <= (out_cnt == N_LAST);
            end
        end
    end

    assign m_axis_tvalid = v2;
    assign m_axis_tdata  = out_data;
    assign m_axis_tlast  = out_last;

endmodule

// File: doc/norm_scaler.md
# norm_scaler

Parametrised pixel normaliser between the crop-filter output and the downstream AXI-Stream consumer. Per frame it computes a fixed-point reciprocal coefficient from `norm_denominator` with a sequential restoring divider, waits for the upstream crop filter to finish, then streams exactly OUT_ROWS*OUT_COLS pixels through a 2-stage multiply/round/saturate pipeline. It uses an ap_start/ap_ready/ap_done handshake, generates `m_axis_tlast`, and honours full backpressure.

## Interface
Parameters:
- PIXEL_BIT_WIDTH, 10, pixel and denominator width W
- FRAC_BITS, 8, fractional bits F of the coefficient
- OUT_ROWS, 10, rows per frame
- OUT_COLS, 10, columns per frame

Ports:
- clk  in  1  single clock
- s_axis_resetn  in  1  reset: asynchronous, active-low
- ap_start  in  1  start-of-frame request, sampled only in IDLE
- ap_ready  out  1  high in IDLE only
- ap_done  out  1  one-cycle pulse when the frame completes
- cf_ap_done  in  1  upstream crop-filter completion pulse
- norm_denominator  in  W  denominator, latched on accepted ap_start
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  W  input pixel
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  W  normalised pixel
- m_axis_tlast  out  1  high on the final pixel of the frame

## Operation
- N = OUT_ROWS*OUT_COLS. MAXV = 2^W-1. Coefficient width C = W+F.
- States: IDLE, DIV, WAIT_CF, STREAM, DONE.
- IDLE: ap_ready=1. ap_start latches the denominator, clears the cf flag and both counters, then goes to DIV.
- DIV: restoring divide of (MAXV<<F) by the denominator, 1 quotient bit per cycle, C cycles, coef = quotient (C bits). Denominator 0: the divider is skipped and coef = all ones, still taking C cycles. Then goes to WAIT_CF.
- cf flag: set by cf_ap_done in any non-IDLE state, including during DIV.
- WAIT_CF: goes to STREAM when the cf flag is set.
- STREAM:
  - s_axis_tready = (in_cnt < N) && (!v2 || m_axis_tready). A global stall enable moves both stages together.
  - Stage 1 registers p = pixel*coef (2W+F bits).
  - Stage 2 registers out = min(rounded p >> F, MAXV) and the last flag (out_cnt == N-1).
  - When the output beat with tlast is accepted, goes to DONE.
- DONE: ap_done=1 for exactly one cycle, then IDLE.
- ap_start outside IDLE is ignored. cf_ap_done in IDLE is ignored. Input beats beyond N are not accepted (tready stays low).
- The asynchronous reset at any time, including mid-frame, forces IDLE, flushes the pipeline and clears counters; in-flight data is discarded.

## Timing
- Reset values: ap_ready=1, ap_done=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
- ap_start accepted at cycle t:
  - ap_ready=0 from t+1.
  - DIV spans t+1..t+C.
  - WAIT_CF is entered at t+C+1.
  - STREAM begins the cycle after the cf flag is observed set in WAIT_CF. Minimum is t+C+2.
- Pipeline latency: 2 cycles from input handshake to m_axis_tvalid, with no stalls.
- Throughput: 1 pixel/cycle under continuous valid/ready.
- AXI rules:
  - m_axis_tdata and m_axis_tlast are held stable while tvalid=1 and tready=0.
  - tvalid is never dropped before the handshake.
- ap_done is asserted the cycle after the final handshake. ap_ready returns high the cycle after ap_done.
- Back-to-back frames: ap_start in the first IDLE cycle after DONE is accepted.

## Configuration
- NORM_SCALER_ROUND_EN defined: round half-up, out = min((p + 2^(F-1)) >> F, MAXV).
- NORM_SCALER_ROUND_EN undefined: truncate, out = min(p >> F, MAXV).
- Latency and handshake are identical in both builds.

## Test plan
All scenarios use defaults: W=10, F=8, C=18, N=100. All values below assume rounding enabled.
- Reset, then ap_start with denominator 1023 and cf_ap_done during DIV -> coef 256; pixel 500 -> 500. STREAM entered at t+20. 100 beats, tlast on beat 100. ap_done at the cycle after the last handshake.
- Denominator 512, pixels 256 and 600 -> coef 511; outputs 511 and 1023 (saturated). With rounding disabled: 511 and 1023.
- Denominator 0 -> coef 0x3FFFF; pixel 0 -> 0, pixel 1 -> 1023. The divide still takes 18 cycles.
- cf_ap_done withheld 50 cycles after DIV -> s_axis_tready stays 0 until the cycle after the flag sets. A second ap_start mid-frame is ignored.
- Random m_axis_tready (50%) with a continuous input -> no lost or duplicated pixels, data stable under stall, exactly 100 outputs, the 101st input is not accepted.
- Reset deasserted-asserted at beat 40 -> outputs return to reset values immediately, IDLE with ap_ready=1. The next frame runs cleanly from beat 0.
